// File: rtl/fnd_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Scans one digit per SCAN_DIV cycles, latches a time snapshot per frame, and flips pages at frame wrap.
module fnd_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 100_000,
    parameter int unsigned BLINK_THRESH = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    input  logic       page_toggle,
    input  logic       blank,
    output logic [3:0] fnd_comm,
    output logic [7:0] fnd_font,
    output logic       page
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [6:0] THRESH = 7'(BLINK_THRESH);

    typedef enum logic {StShow, StPend} state_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_next;
    logic          tick, wrap;
    state_e        state_q, state_d;
    logic          page_q, page_d;
    logic [6:0]    ms_l, s_l, mi_l, h_l;
    logic [3:0]    comm_q;
    logic [7:0]    font_q;

    function automatic logic [6:0] clamp99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    assign tick     = (cnt_q == CNT_MAX);
    assign wrap     = tick && (idx_q == 2'd3);
    assign idx_next = idx_q + 2'd1;
    assign cnt_d    = tick ? '0 : cnt_q + CW'(1);

    // A toggle arriving on the wrap cycle resolves together with any pending one.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        case (state_q)
            StShow: begin
                if (wrap) begin
                    if (page_toggle) page_d = ~page_q;
                end else if (page_toggle) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (wrap) begin
                    state_d = StShow;
                    if (!page_toggle) page_d = ~page_q;
                end else if (page_toggle) begin
                    state_d = StShow;
                end
            end
            default: state_d = StShow;
        endcase
    end

    // Digit 0 is built from live inputs, which are exactly what the latch captures on that edge.
    logic [6:0] src_ms, src_s, src_mi, src_h;
    logic [6:0] val_a, val_b, ms_c, dig_full;
    logic [3:0] digit, dp_mask;
    logic [6:0] seg;

    always_comb begin
        src_ms = wrap ? msec : ms_l;
        src_s  = wrap ? {1'b0, sec} : s_l;
        src_mi = wrap ? {1'b0, min} : mi_l;
        src_h  = wrap ? {2'b00, hour} : h_l;
        ms_c   = clamp99(src_ms);
        val_a  = page_d ? clamp99(src_mi) : ms_c;
        val_b  = page_d ? clamp99(src_h) : clamp99(src_s);
        case (idx_next)
            2'd0:    dig_full = val_a % 7'd10;
            2'd1:    dig_full = val_a / 7'd10;
            2'd2:    dig_full = val_b % 7'd10;
            default: dig_full = val_b / 7'd10;
        endcase
        digit   = dig_full[3:0];
        dp_mask = (ms_c >= THRESH) ? 4'b1010 : 4'b1111;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            default: seg = 7'h10;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            state_q <= StShow;
            page_q  <= 1'b0;
            ms_l    <= '0;
            s_l     <= '0;
            mi_l    <= '0;
            h_l     <= '0;
            comm_q  <= 4'hF;
            font_q  <= 8'hFF;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            page_q  <= page_d;
            if (tick) begin
                idx_q <= idx_next;
                if (blank) begin
                    comm_q <= 4'hF;
                    font_q <= 8'hFF;
                end else begin
                    comm_q <= ~(4'b0001 << idx_next);
                    font_q <= {dp_mask[idx_next], seg};
                end
            end
            if (wrap) begin
                ms_l <= msec;
                s_l  <= {1'b0, sec};
                mi_l <= {1'b0, min};
                h_l  <= {2'b00, hour};
            end
        end
    end

    assign fnd_comm = comm_q;
    assign fnd_font = font_q;
    assign page     = page_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: cycle-count reference model plus literal spot checks.
module tb_fnd_scan_ctrl;

    localparam int SD  = 4;
    localparam int THR = 50;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] msec;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic       page_toggle, blank;
    logic [3:0] fnd_comm;
    logic [7:0] fnd_font;
    logic       page;

    int n_chk  = 0;
    int n_pass = 0;

    fnd_scan_ctrl #(.SCAN_DIV(SD), .BLINK_THRESH(THR)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .msec        (msec),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .page_toggle (page_toggle),
        .blank       (blank),
        .fnd_comm    (fnd_comm),
        .fnd_font    (fnd_font),
        .page        (page)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    endtask

    function automatic logic [6:0] seg7(input int v);
        case (v)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; default: return 7'h10;
        endcase
    endfunction

    function automatic logic [7:0] mfont(input int d, input int ms, input int s, input int mi,
                                         input int h, input logic pg);
        int a, b, v, msc;
        logic dp;
        msc = (ms > 99) ? 99 : ms;
        a = pg ? ((mi > 99) ? 99 : mi) : msc;
        b = pg ? ((h > 99) ? 99 : h) : ((s > 99) ? 99 : s);
        v = (d == 0) ? a % 10 : (d == 1) ? a / 10 : (d == 2) ? b % 10 : b / 10;
        dp = (msc >= THR && (d == 0 || d == 2)) ? 1'b0 : 1'b1;
        return {dp, seg7(v)};
    endfunction

    // Reference model: everything follows from the cycle count since reset release.
    int         m_cyc;
    int         sn_ms, sn_s, sn_mi, sn_h;
    logic       m_pend, m_page;
    logic [3:0] exp_comm;
    logic [7:0] exp_font;
    logic       m_tick, m_wrap, m_newpage;
    int         m_d;

    assign m_tick    = (m_cyc % SD) == SD - 1;
    assign m_wrap    = m_tick && ((m_cyc / SD) % 4 == 3);
    assign m_d       = ((m_cyc / SD) + 1) % 4;
    assign m_newpage = m_page ^ (m_pend ^ page_toggle);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc <= 0; sn_ms <= 0; sn_s <= 0; sn_mi <= 0; sn_h <= 0;
            m_pend <= 1'b0; m_page <= 1'b0; exp_comm <= 4'hF; exp_font <= 8'hFF;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_wrap) begin
                sn_ms <= int'(msec); sn_s <= int'(sec); sn_mi <= int'(min); sn_h <= int'(hour);
                m_page <= m_newpage;
                m_pend <= 1'b0;
            end else begin
                m_pend <= m_pend ^ page_toggle;
            end
            if (m_tick) begin
                if (blank) begin
                    exp_comm <= 4'hF;
                    exp_font <= 8'hFF;
                end else begin
                    exp_comm <= ~(4'b0001 << m_d);
                    if (m_wrap) exp_font <= mfont(0, int'(msec), int'(sec), int'(min), int'(hour), m_newpage);
                    else        exp_font <= mfont(m_d, sn_ms, sn_s, sn_mi, sn_h, m_page);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_comm", {28'd0, fnd_comm}, {28'd0, exp_comm});
        chk("model_font", {24'd0, fnd_font}, {24'd0, exp_font});
        chk("model_page", {31'd0, page}, {31'd0, m_page});
    end

    task automatic wait_d0();
        int i;
        i = 0;
        while (fnd_comm === 4'b1110 && i < 12 * SD) begin @(negedge clk); i++; end
        while (fnd_comm !== 4'b1110 && i < 12 * SD) begin @(negedge clk); i++; end
        chk("wait_digit0", {28'd0, fnd_comm}, 32'hE);
    endtask

    task automatic dp_frame(input logic [3:0] mask, input string nm);
        wait_d0();
        for (int d = 0; d < 4; d++) begin
            chk(nm, {31'd0, fnd_font[7]}, {31'd0, mask[d]});
            repeat (SD) @(negedge clk);
        end
    endtask

    task automatic pulse_toggle();
        page_toggle = 1'b1;
        @(negedge clk);
        page_toggle = 1'b0;
    endtask

    logic [3:0] e;

    initial begin
        reset_n = 1'b0; msec = 7'd37; sec = 6'd42; min = 6'd0; hour = 5'd0;
        page_toggle = 1'b0; blank = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Power-up sequence and first sec:msec frame
        for (int k = 0; k < 32; k++) begin
            if (k < 4) e = 4'hF;
            else begin
                e = 4'b0001 << (((k - 4) / 4 + 1) % 4);
                e = ~e;
            end
            chk("comm_seq", {28'd0, fnd_comm}, {28'd0, e});
            if (k == 4)  chk("font_latch0", {24'd0, fnd_font}, 32'hC0);
            if (k == 16) chk("font_d0", {24'd0, fnd_font}, 32'hF8);
            if (k == 20) chk("font_d1", {24'd0, fnd_font}, 32'hB0);
            if (k == 24) chk("font_d2", {24'd0, fnd_font}, 32'hA4);
            if (k == 28) chk("font_d3", {24'd0, fnd_font}, 32'h99);
            @(negedge clk);
        end

        msec = 7'd75; dp_frame(4'b1010, "dp_75");
        msec = 7'd49; dp_frame(4'b1111, "dp_49");
        msec = 7'd50; dp_frame(4'b1010, "dp_50");
        msec = 7'd37;

        // Frame coherence: sec changes while digit 1 is shown
        wait_d0();
        repeat (SD) @(negedge clk);
        sec = 6'd43;
        repeat (SD) @(negedge clk);
        chk("coh_d2_old", {24'd0, fnd_font}, 32'hA4);
        repeat (SD) @(negedge clk);
        chk("coh_d3_old", {24'd0, fnd_font}, 32'h99);
        repeat (2 * SD) @(negedge clk);
        chk("coh_d1_new", {28'd0, fnd_comm}, 32'hD);
        repeat (SD) @(negedge clk);
        chk("coh_d2_new", {24'd0, fnd_font}, 32'hB0);

        // Page flip requested mid-frame
        hour = 5'd23; min = 6'd5;
        wait_d0();
        repeat (SD) @(negedge clk);
        pulse_toggle();
        chk("page_hold", {31'd0, page}, 32'd0);
        wait_d0();
        chk("page_flip", {31'd0, page}, 32'd1);
        chk("hm_d0", {24'd0, fnd_font}, 32'h92);
        repeat (SD) @(negedge clk);
        chk("hm_d1", {24'd0, fnd_font}, 32'hC0);
        repeat (SD) @(negedge clk);
        chk("hm_d2", {24'd0, fnd_font}, 32'hB0);
        repeat (SD) @(negedge clk);
        chk("hm_d3", {24'd0, fnd_font}, 32'hA4);

        // Two pulses in one frame cancel
        wait_d0();
        repeat (SD) @(negedge clk);
        pulse_toggle();
        repeat (SD) @(negedge clk);
        pulse_toggle();
        wait_d0();
        chk("page_cancel", {31'd0, page}, 32'd1);

        // Pulse coincident with the wrap tick
        wait_d0();
        repeat (4 * SD - 1) @(negedge clk);
        pulse_toggle();
        chk("wrap_pulse_comm", {28'd0, fnd_comm}, 32'hE);
        chk("wrap_pulse_page", {31'd0, page}, 32'd0);

        // Blank mid-frame
        wait_d0();
        repeat (SD + 1) @(negedge clk);
        blank = 1'b1;
        @(negedge clk);
        chk("blank_delay", {28'd0, fnd_comm}, 32'hD);
        repeat (SD - 2) @(negedge clk);
        chk("blank_comm", {28'd0, fnd_comm}, 32'hF);
        chk("blank_font", {24'd0, fnd_font}, 32'hFF);
        repeat (2 * SD) @(negedge clk);
        blank = 1'b0;
        repeat (SD) @(negedge clk);
        chk("unblank_idx", {28'd0, fnd_comm}, 32'hD);

        // Asynchronous reset mid-frame with page 1
        pulse_toggle();
        wait_d0();
        chk("pre_reset_page", {31'd0, page}, 32'd1);
        repeat (SD + 2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_comm", {28'd0, fnd_comm}, 32'hF);
        chk("rst_font", {24'd0, fnd_font}, 32'hFF);
        chk("rst_page", {31'd0, page}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Clamp of out-of-range msec
        msec = 7'd120;
        wait_d0();
        chk("clamp_d0", {24'd0, fnd_font}, 32'h10);
        repeat (SD) @(negedge clk);
        chk("clamp_d1", {24'd0, fnd_font}, 32'h90);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            msec        = 7'($urandom_range(0, 127));
            sec         = 6'($urandom_range(0, 63));
            min         = 6'($urandom_range(0, 63));
            hour        = 5'($urandom_range(0, 31));
            page_toggle = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) blank = ~blank;
        end
        page_toggle = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode 7-segment display on the stopwatch/watch board. It sits between the time counters (msec/sec/min/hour) and the FND pins. It generates the digit scan rate, latches one coherent time snapshot per frame, and selects the displayed page (sec:msec or hour:min). It also converts the values to decimal digits and applies the half-second dot blink.

## Interface
- SCAN_DIV, 100_000: clk cycles per digit slot (100 MHz → 1 kHz per digit).
- BLINK_THRESH, 50: msec value at or above which the dots are lit.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- msec  in  7  0–99, live from the time counter.
- sec  in  6  0–59.
- min  in  6  0–59.
- hour  in  5  0–23.
- page_toggle  in  1  single-cycle pulse, already debounced and synchronised; requests a page flip.
- blank  in  1  level; high forces all digits off.
- fnd_comm  out  4  active-low digit enables; bit0 is the rightmost digit.
- fnd_font  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- page  out  1  current displayed page: 0 = sec:msec, 1 = hour:min.

## Operation
- Prescaler counts 0..SCAN_DIV-1 and wraps. `tick` is an internal signal, high for one cycle when the count equals SCAN_DIV-1.
- Digit index idx (2 bits) advances on each tick: 0→1→2→3→0. A frame is idx 0..3.
- Frame latch:
  - On the tick where idx==3, msec/sec/min/hour are captured into the latch.
  - Digits 1–3 of the frame come from the latch. Mixed-frame values are never shown.
- Page FSM, states SHOW (no pending flip) and PEND (flip pending):
  - SHOW + page_toggle → PEND.
  - PEND + page_toggle → SHOW, because two requests cancel.
  - PEND + tick with idx==3 → page inverts, then SHOW.
  - A page_toggle in the same cycle as the wrap tick counts as arriving before the wrap, so it is applied in that wrap.
  - Page therefore only changes at frame boundaries.
- Digit mapping:
  - Page 0: d0 = msec%10, d1 = msec/10, d2 = sec%10, d3 = sec/10.
  - Page 1: d0 = min%10, d1 = min/10, d2 = hour%10, d3 = hour/10.
- Clamp: any input value above 99 is treated as 99. No other range check is made.
- Segment codes, bits [6:0], 0–9: 40,79,24,30,19,12,02,78,00,10 (hex).
- Dot:
  - The dp mask is 4'b1010 (active-low: dots on digits 0 and 2) when the frame's msec ≥ BLINK_THRESH, else 4'b1111.
  - The mask is applied on both pages.
  - fnd_font[7] = mask[idx].
- Blank:
  - fnd_comm = 4'b1111 and fnd_font = 8'hFF while blank is high.
  - The prescaler, idx, the latch and the page FSM keep running while blanked.

## Timing
- Reset values:
  - prescaler 0, idx 0, page 0, state SHOW, latch all 0.
  - fnd_comm 4'b1111, fnd_font 8'hFF.
  - Reset is asynchronous and may assert mid-frame; all state clears immediately.
- The first tick occurs SCAN_DIV cycles after reset_n deasserts. The display stays dark until that tick.
- Outputs are registered and update only on tick edges, with a latency of one clk after the tick cycle.
  - fnd_comm = ~(4'b0001 << idx_next).
  - fnd_font is the segment code for digit idx_next.
- On the wrap edge (idx 3→0), digit 0 is computed from the live inputs and the resolved page. That matches the values captured into the latch on the same edge.
- page output changes on the same edge as the wrap.
- A blank change takes effect at the next tick edge, not immediately.
- Each digit is lit for exactly SCAN_DIV cycles; a full frame is 4·SCAN_DIV cycles.

## Test plan
- Reset, SCAN_DIV=4, msec=37, sec=42 → fnd_comm=1111/font=FF for 4 cycles. Then the comm sequence is 1101, 1011, 0111, 1110, each held 4 cycles.
- Sec:msec digits, one full frame with msec=37, sec=42 → fonts in order d0..d3 = F8,B0,A4,99, all with dp off (msec<50).
- Dot blink, msec=75 → dp low on digits 0 and 2 only; msec=49 → dp high on all digits; msec=50 → lit.
- Frame coherence: change sec 42→43 while idx=1 → digits 2–3 still show 42 until after the next wrap.
- Page toggle:
  - A pulse at idx=1 flips page only at the next 3→0 wrap; with hour=23, min=05 the frame then shows 05,23.
  - Two pulses within the same frame → no flip.
  - A pulse exactly on the wrap tick flips at that wrap.
- Blank and reset:
  - blank=1 mid-frame → 1111/FF from the next tick, and idx keeps advancing.
  - reset_n low mid-frame → outputs 1111/FF and page 0 immediately.
  - msec=120 input → displayed as 99.
